// File: rtl/booth_mult_if.sv
// Start/busy/done handshake and operand/result bus of the sequential Booth multiplier.
// The control unit drives the master side; the multiplier is the slave.
interface booth_mult_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             signed_op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, signed_op, a, b,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, signed_op, a, b,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier: one iteration per clock on WIDTH+1-bit
// extended operands, signed or unsigned per operation, result split into hi/lo.
module booth_mult_seq #(
    parameter int WIDTH = 32
) (
    input  logic         i_clk,
    input  logic         i_reset,
    booth_mult_if.slave  if_mul
);
    localparam int W1 = WIDTH + 1;
    localparam int CW = $clog2(WIDTH + 2);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_accept;
    logic             w_last;

    logic [W1-1:0]    r_acc;
    logic [W1-1:0]    r_q;
    logic             r_q1;
    logic [W1-1:0]    r_m;
    logic [CW-1:0]    r_count;
    logic             r_signed;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic [W1-1:0]      w_a_ext;
    logic [W1-1:0]      w_b_ext;
    logic [W1-1:0]      w_sum;
    logic [W1-1:0]      w_acc_sh;
    logic [W1-1:0]      w_q_sh;
    logic [2*WIDTH-1:0] w_result;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic, accept and last-iteration strobes
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (if_mul.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (r_count == CW'(1)) begin
                    w_last      = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand extension, Booth add/subtract, arithmetic shift and result select
    always_comb begin
        w_a_ext = {1'b0, if_mul.a};
        w_b_ext = {1'b0, if_mul.b};
        if (if_mul.signed_op) begin
            w_a_ext = {if_mul.a[WIDTH-1], if_mul.a};
            w_b_ext = {if_mul.b[WIDTH-1], if_mul.b};
        end else begin
            w_a_ext = {1'b0, if_mul.a};
            w_b_ext = {1'b0, if_mul.b};
        end

        case ({r_q[0], r_q1})
            2'b10:   w_sum = r_acc - r_m;
            2'b01:   w_sum = r_acc + r_m;
            default: w_sum = r_acc;
        endcase

        w_acc_sh = {w_sum[WIDTH], w_sum[WIDTH:1]};
        w_q_sh   = {w_sum[0], r_q[WIDTH:1]};

        // A signed run does one fewer shift, so the unused sign bit of Q still sits in Q[0]
        if (r_signed) begin
            w_result = {w_acc_sh[WIDTH-1:0], w_q_sh[WIDTH:1]};
        end else begin
            w_result = {w_acc_sh[WIDTH-2:0], w_q_sh};
        end
    end

    // Datapath registers and registered handshake outputs
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_acc    <= {W1{1'b0}};
            r_q      <= {W1{1'b0}};
            r_q1     <= 1'b0;
            r_m      <= {W1{1'b0}};
            r_count  <= {CW{1'b0}};
            r_signed <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= {WIDTH{1'b0}};
            r_lo     <= {WIDTH{1'b0}};
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_m      <= w_a_ext;
                r_q      <= w_b_ext;
                r_acc    <= {W1{1'b0}};
                r_q1     <= 1'b0;
                r_signed <= if_mul.signed_op;
                r_count  <= if_mul.signed_op ? CW'(WIDTH) : CW'(WIDTH + 1);
                r_busy   <= 1'b1;
            end else if (r_state == S_RUN) begin
                r_acc   <= w_acc_sh;
                r_q     <= w_q_sh;
                r_q1    <= r_q[0];
                r_count <= r_count - CW'(1);
                if (w_last) begin
                    r_hi   <= w_result[2*WIDTH-1:WIDTH];
                    r_lo   <= w_result[WIDTH-1:0];
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
            end
        end
    end

    assign if_mul.busy = r_busy;
    assign if_mul.done = r_done;
    assign if_mul.hi   = r_hi;
    assign if_mul.lo   = r_lo;
endmodule

// File: tb/tb_booth_mult_seq.sv
// Scoreboard bench for booth_mult_seq: WIDTH=32 and WIDTH=8 instances, directed
// vectors, per-instance monitors checking hi/lo and accept-to-done latency.
module tb_booth_mult_seq;
    typedef struct {
        logic [63:0] prod;
        int          acc;
        int          iter;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   errors;
    exp_t q32[$];
    exp_t q8[$];

    booth_mult_if #(.WIDTH(32)) if32 ();
    booth_mult_if #(.WIDTH(8))  if8 ();

    booth_mult_seq #(.WIDTH(32)) dut32 (
        .i_clk   (clk),
        .i_reset (reset),
        .if_mul  (if32)
    );

    booth_mult_seq #(.WIDTH(8)) dut8 (
        .i_clk   (clk),
        .i_reset (reset),
        .if_mul  (if8)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic mon32();
        exp_t e;
        forever begin
            @(negedge clk);
            if (if32.done === 1'b1) begin
                if (q32.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL done32_unexpected: got done=1 required no pending operation");
                end else begin
                    e = q32.pop_front();
                    chk("hi32", 64'(if32.hi), 64'(e.prod[63:32]));
                    chk("lo32", 64'(if32.lo), 64'(e.prod[31:0]));
                    chk("latency32", 64'(cyc - e.acc), 64'(e.iter));
                end
            end
        end
    endtask

    task automatic mon8();
        exp_t e;
        forever begin
            @(negedge clk);
            if (if8.done === 1'b1) begin
                if (q8.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL done8_unexpected: got done=1 required no pending operation");
                end else begin
                    e = q8.pop_front();
                    chk("hi8", 64'(if8.hi), 64'(e.prod[15:8]));
                    chk("lo8", 64'(if8.lo), 64'(e.prod[7:0]));
                    chk("latency8", 64'(cyc - e.acc), 64'(e.iter));
                end
            end
        end
    endtask

    // Called at a negedge; start is seen by the next posedge, then operands are scrambled.
    task automatic issue32(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                           input logic [63:0] prod, input logic push);
        if32.a         = a;
        if32.b         = b;
        if32.signed_op = sgn;
        if32.start     = 1'b1;
        if (push) q32.push_back('{prod, cyc + 1, sgn ? 32 : 33});
        @(negedge clk);
        if32.start     = 1'b0;
        if32.a         = ~a;
        if32.b         = b ^ 32'h5A5A_5A5A;
        if32.signed_op = ~sgn;
    endtask

    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic sgn,
                          input logic [15:0] prod);
        if8.a         = a;
        if8.b         = b;
        if8.signed_op = sgn;
        if8.start     = 1'b1;
        q8.push_back('{64'(prod), cyc + 1, sgn ? 8 : 9});
        @(negedge clk);
        if8.start     = 1'b0;
        if8.a         = ~a;
        if8.b         = ~b;
        if8.signed_op = ~sgn;
    endtask

    task automatic wait_done32();
        for (int i = 0; i < 100; i++) begin
            if (if32.done === 1'b1) break;
            @(negedge clk);
        end
        chk("done32_seen", 64'(if32.done), 64'd1);
    endtask

    task automatic wait_done8();
        for (int i = 0; i < 100; i++) begin
            if (if8.done === 1'b1) break;
            @(negedge clk);
        end
        chk("done8_seen", 64'(if8.done), 64'd1);
    endtask

    initial begin
        clk    = 1'b0;
        reset  = 1'b1;
        cyc    = 0;
        checks = 0;
        errors = 0;
        if32.start = 1'b0; if32.signed_op = 1'b0; if32.a = 32'd0; if32.b = 32'd0;
        if8.start  = 1'b0; if8.signed_op  = 1'b0; if8.a  = 8'd0;  if8.b  = 8'd0;
        fork
            mon32();
            mon8();
        join_none
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_busy32", 64'(if32.busy), 64'd0);
        chk("rst_done32", 64'(if32.done), 64'd0);
        chk("rst_hi32",   64'(if32.hi),   64'd0);
        chk("rst_lo32",   64'(if32.lo),   64'd0);
        chk("rst_busy8",  64'(if8.busy),  64'd0);
        chk("rst_lo8",    64'(if8.lo),    64'd0);

        // -3 * 7 signed
        issue32(32'hFFFF_FFFD, 32'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB, 1'b1);
        chk("busy32_run", 64'(if32.busy), 64'd1);
        wait_done32();
        // max * max unsigned
        issue32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 1'b1);
        wait_done32();
        // MIN * MIN signed, then 2^31 * 2 unsigned
        issue32(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 1'b1);
        wait_done32();
        issue32(32'h8000_0000, 32'd2, 1'b0, 64'h0000_0001_0000_0000, 1'b1);
        wait_done32();

        // 100 * -2 signed with a stray start pulse mid-run
        issue32(32'd100, 32'hFFFF_FFFE, 1'b1, 64'hFFFF_FFFF_FFFF_FF38, 1'b1);
        repeat (9) @(negedge clk);
        if32.a = 32'd5; if32.b = 32'd5; if32.signed_op = 1'b1; if32.start = 1'b1;
        chk("busy32_ignored_start", 64'(if32.busy), 64'd1);
        @(negedge clk);
        if32.start = 1'b0;
        wait_done32();
        @(negedge clk);
        chk("done32_one_cycle", 64'(if32.done), 64'd0);
        chk("hold_hi32", 64'(if32.hi), 64'hFFFF_FFFF);

        // Abort mid-run with reset: nothing queued, so any done is flagged
        issue32(32'd12345, 32'd678, 1'b1, 64'd0, 1'b0);
        repeat (14) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy32", 64'(if32.busy), 64'd0);
        chk("abort_done32", 64'(if32.done), 64'd0);
        chk("abort_hi32",   64'(if32.hi),   64'd0);
        chk("abort_lo32",   64'(if32.lo),   64'd0);
        repeat (40) @(negedge clk);

        issue32(32'd6, 32'd7, 1'b1, 64'h0000_0000_0000_002A, 1'b1);
        wait_done32();

        // 8-bit: -128 * -1 signed, then unsigned FF*FF started in the done cycle
        issue8(8'h80, 8'hFF, 1'b1, 16'h0080);
        wait_done8();
        issue8(8'hFF, 8'hFF, 1'b0, 16'hFE01);
        chk("b2b_busy8", 64'(if8.busy), 64'd1);
        chk("b2b_done8_drop", 64'(if8.done), 64'd0);
        wait_done8();

        repeat (5) @(negedge clk);
        chk("q32_empty", 64'(q32.size()), 64'd0);
        chk("q8_empty",  64'(q8.size()),  64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
